// File: rtl/timebase_prescaler_pkg.sv
// Shared constants and state encoding for the timebase prescaler and the
// terminal-count comparator stage that consumes count_o.
package timebase_prescaler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

    // 8 s period at 50 MHz: 400_000_000 cycles, last count 399_999_999.
    localparam int unsigned CNT_W_DEF    = 29;
    localparam int unsigned TERMINAL_DEF = 399_999_999;
    localparam int unsigned EVT_W_DEF    = 8;

    // True when value is representable in an unsigned field of width bits.
    function automatic bit fits_width(input longint unsigned value, input int unsigned width);
        if (width >= 64) return 1'b1;
        return value < (64'd1 << width);
    endfunction

endpackage

// File: rtl/timebase_prescaler_counter.sv
// Enable/clear counter that wraps to zero after reaching terminal and
// registers a one-cycle wrap pulse on the same edge the wrap happens.
module tb_mod_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] terminal,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_q;
    logic         wrap_q;
    logic         at_wrap;

    // Wrap only when actually counting; a frozen count at terminal does not wrap.
    assign at_wrap = en && (count_q == terminal);

    // Counter and wrap pulse; clr overrides counting on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else if (clr) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            wrap_q <= at_wrap;
            if (at_wrap) begin
                count_q <= '0;
            end else if (en) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule

// File: rtl/timebase_prescaler.sv
// Free-running cycle timebase: IDLE/RUN/HOLD control, a cycle counter that
// wraps at TERMINAL with a tick per period, and a modulo tally of periods.
module timebase_prescaler
    import timebase_prescaler_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned TERMINAL = TERMINAL_DEF,
    parameter int unsigned EVT_W    = EVT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    output logic [0:CNT_W-1] count_o,
    output logic             tick_o,
    output logic [EVT_W-1:0] evt_o,
    output logic             evt_ovf_o,
    output logic             running_o,
    output state_e           dbg_state
);

    if (!fits_width(TERMINAL, CNT_W)) begin : g_bad_terminal
        $error("timebase_prescaler: TERMINAL does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] TERM_V    = CNT_W'(TERMINAL);
    localparam logic [EVT_W-1:0] EVT_TERM  = {EVT_W{1'b1}};

    state_e           state_q;
    state_e           state_d;
    logic             running_q;
    logic             cnt_en;
    logic             evt_en;
    logic [CNT_W-1:0] cyc_count;
    logic [EVT_W-1:0] evt_count;
    logic             cyc_wrap;
    logic             evt_wrap;

    // Next-state: clear dominates, and stop beats a simultaneous start.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start && !stop) state_d = ST_RUN;
                ST_RUN:  if (stop)           state_d = ST_HOLD;
                ST_HOLD: if (start && !stop) state_d = ST_RUN;
                default:                     state_d = ST_IDLE;
            endcase
        end
    end

    // State register and registered running flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == ST_RUN);
        end
    end

    // Count only in RUN; a stop seen this cycle freezes the count on this edge,
    // so stopping at TERMINAL defers the wrap until the first RUN cycle after resume.
    assign cnt_en = (state_q == ST_RUN) && !stop;
    assign evt_en = cnt_en && (cyc_count == TERM_V);

    tb_mod_counter #(.W(CNT_W)) u_cyc (
        .clk      (clk),
        .rst      (rst),
        .en       (cnt_en),
        .clr      (clear),
        .terminal (TERM_V),
        .count    (cyc_count),
        .wrap     (cyc_wrap)
    );

    tb_mod_counter #(.W(EVT_W)) u_evt (
        .clk      (clk),
        .rst      (rst),
        .en       (evt_en),
        .clr      (clear),
        .terminal (EVT_TERM),
        .count    (evt_count),
        .wrap     (evt_wrap)
    );

    // count_o is MSB-first ([0:CNT_W-1]); this maps MSB to bit 0.
    assign count_o   = cyc_count;
    assign tick_o    = cyc_wrap;
    assign evt_o     = evt_count;
    assign evt_ovf_o = evt_wrap;
    assign running_o = running_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_timebase_prescaler.sv
// Directed bench: small instance (TERMINAL=9, EVT_W=2) for the control and
// wrap scenarios, plus a default-parameter instance for the full-width wrap.
module tb_timebase_prescaler;
    import timebase_prescaler_pkg::*;

    localparam int CNT_W = 29;
    localparam int EVT_W = 2;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             start = 1'b0;
    logic             stop  = 1'b0;
    logic             clear = 1'b0;
    logic [0:CNT_W-1] count_o;
    logic             tick_o;
    logic [EVT_W-1:0] evt_o;
    logic             evt_ovf_o;
    logic             running_o;
    state_e           dbg_state;

    logic             start2 = 1'b0;
    logic             stop2  = 1'b0;
    logic             clear2 = 1'b0;
    logic [0:28]      count2;
    logic             tick2;
    logic [7:0]       evt2;
    logic             ovf2;
    logic             run2;
    state_e           st2;

    int n_cmp = 0;
    int n_bad = 0;

    // clock
    always #5 clk = ~clk;

    timebase_prescaler #(.CNT_W(CNT_W), .TERMINAL(9), .EVT_W(EVT_W)) u_dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .count_o(count_o), .tick_o(tick_o), .evt_o(evt_o), .evt_ovf_o(evt_ovf_o),
        .running_o(running_o), .dbg_state(dbg_state)
    );

    timebase_prescaler u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .stop(stop2), .clear(clear2),
        .count_o(count2), .tick_o(tick2), .evt_o(evt2), .evt_ovf_o(ovf2),
        .running_o(run2), .dbg_state(st2)
    );

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        n_cmp++;
        if (count_o !== '0 || tick_o !== 1'b0 || evt_o !== '0 || evt_ovf_o !== 1'b0 ||
            running_o !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_bad++;
            $display("FAIL reset_values: count=%0d tick=%b evt=%0d ovf=%b run=%b st=%0d, want all 0",
                     count_o, tick_o, evt_o, evt_ovf_o, running_o, dbg_state);
        end
        rst = 1'b0;
        cyc();
        do_start();
        repeat (5) cyc();
        n_cmp++;
        if (count_o !== 29'd5 || running_o !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_precount: count=%0d run=%b, want 5 1", count_o, running_o);
        end
        // assert reset between edges: outputs must clear without a clock
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (count_o !== '0 || tick_o !== 1'b0 || evt_o !== '0 || evt_ovf_o !== 1'b0 ||
            running_o !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_bad++;
            $display("FAIL reset_async: count=%0d tick=%b evt=%0d ovf=%b run=%b st=%0d, want all 0",
                     count_o, tick_o, evt_o, evt_ovf_o, running_o, dbg_state);
        end
        cyc();
        rst = 1'b0;
        cyc();
        cyc();
        n_cmp++;
        if (count_o !== '0 || tick_o !== 1'b0 || running_o !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_bad++;
            $display("FAIL reset_after: count=%0d tick=%b run=%b st=%0d, want 0 0 0 IDLE",
                     count_o, tick_o, running_o, dbg_state);
        end
    endtask

    task automatic test_run();
        int   exp_c;
        int   exp_e;
        logic exp_t;
        do_start();
        for (int i = 1; i <= 30; i++) begin
            exp_c = (i - 1) % 10;
            exp_t = (i == 11 || i == 21);
            exp_e = (i >= 21) ? 2 : ((i >= 11) ? 1 : 0);
            n_cmp++;
            if (count_o !== CNT_W'(exp_c) || tick_o !== exp_t || evt_o !== EVT_W'(exp_e) ||
                running_o !== 1'b1) begin
                n_bad++;
                $display("FAIL run_cycle%0d: count=%0d tick=%b evt=%0d run=%b, want %0d %b %0d 1",
                         i, count_o, tick_o, evt_o, running_o, exp_c, exp_t, exp_e);
            end
            cyc();
        end
        do_clear();
    endtask

    task automatic test_evt_overflow();
        int   exp_c;
        int   exp_e;
        logic exp_t;
        logic exp_o;
        do_start();
        for (int i = 1; i <= 42; i++) begin
            exp_c = (i - 1) % 10;
            exp_t = (i > 1) && (i % 10 == 1);
            exp_e = ((i - 1) / 10) % 4;
            exp_o = (i == 41);
            n_cmp++;
            if (count_o !== CNT_W'(exp_c) || tick_o !== exp_t || evt_o !== EVT_W'(exp_e) ||
                evt_ovf_o !== exp_o) begin
                n_bad++;
                $display("FAIL ovf_cycle%0d: count=%0d tick=%b evt=%0d ovf=%b, want %0d %b %0d %b",
                         i, count_o, tick_o, evt_o, evt_ovf_o, exp_c, exp_t, exp_e, exp_o);
            end
            cyc();
        end
        do_clear();
    endtask

    task automatic test_hold();
        do_start();
        repeat (9) cyc();
        n_cmp++;
        if (count_o !== 29'd9 || tick_o !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_pre: count=%0d tick=%b, want 9 0", count_o, tick_o);
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        n_cmp++;
        if (count_o !== 29'd9 || tick_o !== 1'b0 || running_o !== 1'b0 ||
            dbg_state !== ST_HOLD || evt_o !== '0) begin
            n_bad++;
            $display("FAIL hold_enter: count=%0d tick=%b run=%b st=%0d evt=%0d, want 9 0 0 HOLD 0",
                     count_o, tick_o, running_o, dbg_state, evt_o);
        end
        for (int i = 0; i < 5; i++) begin
            stop = (i == 2);
            start = (i == 4);
            if (i == 4) stop = 1'b1;
            cyc();
            stop  = 1'b0;
            start = 1'b0;
            n_cmp++;
            if (count_o !== 29'd9 || tick_o !== 1'b0 || dbg_state !== ST_HOLD) begin
                n_bad++;
                $display("FAIL hold_cycle%0d: count=%0d tick=%b st=%0d, want 9 0 HOLD",
                         i, count_o, tick_o, dbg_state);
            end
        end
        do_start();
        n_cmp++;
        if (count_o !== 29'd9 || tick_o !== 1'b0 || running_o !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_resume1: count=%0d tick=%b run=%b, want 9 0 1",
                     count_o, tick_o, running_o);
        end
        cyc();
        n_cmp++;
        if (count_o !== 29'd0 || tick_o !== 1'b1 || evt_o !== 2'd1) begin
            n_bad++;
            $display("FAIL hold_resume2: count=%0d tick=%b evt=%0d, want 0 1 1",
                     count_o, tick_o, evt_o);
        end
        cyc();
        n_cmp++;
        if (count_o !== 29'd1 || tick_o !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_resume3: count=%0d tick=%b, want 1 0", count_o, tick_o);
        end
        do_clear();
    endtask

    task automatic test_clear();
        do_start();
        repeat (19) cyc();
        n_cmp++;
        if (count_o !== 29'd9 || evt_o !== 2'd1 || running_o !== 1'b1) begin
            n_bad++;
            $display("FAIL clear_pre: count=%0d evt=%0d run=%b, want 9 1 1",
                     count_o, evt_o, running_o);
        end
        do_clear();
        n_cmp++;
        if (count_o !== '0 || tick_o !== 1'b0 || running_o !== 1'b0 || evt_o !== '0 ||
            evt_ovf_o !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_bad++;
            $display("FAIL clear_at_terminal: count=%0d tick=%b run=%b evt=%0d ovf=%b st=%0d, want 0 0 0 0 0 IDLE",
                     count_o, tick_o, running_o, evt_o, evt_ovf_o, dbg_state);
        end
        start = 1'b1;
        stop  = 1'b1;
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        n_cmp++;
        if (running_o !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_bad++;
            $display("FAIL idle_start_stop: run=%b st=%0d, want 0 IDLE", running_o, dbg_state);
        end
        cyc();
        n_cmp++;
        if (count_o !== '0 || tick_o !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_frozen: count=%0d tick=%b, want 0 0", count_o, tick_o);
        end
    endtask

    task automatic test_default_params();
        int ticks;
        int exp_c;
        force u_dut2.u_cyc.count_q = 29'd399_999_997;
        cyc();
        release u_dut2.u_cyc.count_q;
        cyc();
        n_cmp++;
        if (count2 !== 29'd399_999_997 || run2 !== 1'b0) begin
            n_bad++;
            $display("FAIL dflt_preload: count=%0d run=%b, want 399999997 0", count2, run2);
        end
        start2 = 1'b1;
        cyc();
        start2 = 1'b0;
        ticks = 0;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            if (tick2 === 1'b1) ticks++;
            exp_c = (i == 3) ? 0 : 399_999_997 + i;
            n_cmp++;
            if (count2 !== 29'(exp_c)) begin
                n_bad++;
                $display("FAIL dflt_cycle%0d: count=%0d, want %0d", i, count2, exp_c);
            end
        end
        n_cmp++;
        if (ticks != 1 || tick2 !== 1'b1 || evt2 !== 8'd1 || ovf2 !== 1'b0) begin
            n_bad++;
            $display("FAIL dflt_wrap: ticks=%0d tick=%b evt=%0d ovf=%b, want 1 1 1 0",
                     ticks, tick2, evt2, ovf2);
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_evt_overflow();
        test_hold();
        test_clear();
        test_default_params();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // hard time limit
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
